cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Converts between the cache's 256-bit line interface and the 64-bit, four-beat burst interface of physical memory. On a fill it collects four memory beats into one registered 256-bit line. That line feeds the cache data array and, downstream of it, the 32:1 byte-select mux. On an eviction it serializes a 256-bit dirty line into four beats. It sits between the cache controller/data array and the physical-memory port.

## Interface
- `LINE_BITS`, default 256: cache line width. Fixed at 4 × `BEAT_BITS`.
- `BEAT_BITS`, default 64: memory burst beat width.
- `ADDR_WIDTH`, default 32: byte address width. The offset width is 5 bits for a 32-byte line.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `address_i`, input, `ADDR_WIDTH`: cache-side request address. Offset bits are ignored.
- `read_i`, input, 1: cache requests a line fill.
- `write_i`, input, 1: cache requests a line write-back.
- `line_i`, input, `LINE_BITS`: line to write back. Sampled at accept.
- `line_o`, output, `LINE_BITS`: assembled fill line, registered.
- `resp_o`, output, 1: one-cycle completion pulse for either operation.
- `address_o`, output, `ADDR_WIDTH`: line-aligned memory address, registered.
- `read_o`, output, 1: memory burst read request.
- `write_o`, output, 1: memory burst write request.
- `burst_o`, output, `BEAT_BITS`: current write beat.
- `burst_i`, input, `BEAT_BITS`: read beat data. Valid only when `resp_i` = 1.
- `resp_i`, input, 1: memory beat acknowledge. One pulse per beat.

## Operation
- **State machine.** States are IDLE, RD, RD_DONE, WR, WR_DONE. A 2-bit beat counter `cnt` tracks progress.
- **Accepting a request (IDLE).**
  - If `write_i` = 1, go to WR. Write takes priority if both requests are high, because eviction precedes fill.
  - Else if `read_i` = 1, go to RD.
  - On accept, latch `address_o` = {`address_i`[31:5], 5'b0}, latch `line_i` into the internal write buffer, and set `cnt` = 0.
- **Fill (RD).**
  - `read_o` = 1.
  - On each cycle with `resp_i` = 1, write `burst_i` into `line_o`[64·cnt+63 : 64·cnt] and increment `cnt`.
  - When the beat with `cnt` = 3 is captured, go to RD_DONE.
  - `line_o` bits not yet written keep their previous contents during the fill.
- **Write-back (WR).**
  - `write_o` = 1 and `burst_o` = buffer[64·cnt+63 : 64·cnt].
  - On `resp_i` = 1, increment `cnt`. On the beat with `cnt` = 3, go to WR_DONE.
- **Completion (RD_DONE / WR_DONE).** `resp_o` = 1 for exactly one cycle, `read_o` and `write_o` are 0, then the block returns to IDLE.
- **Requester rule.** The requester must drop `read_i`/`write_i` in the `resp_o` cycle. A request still high in IDLE after that is treated as a new request.
- **Line stability.** `line_o` is stable from RD_DONE until the first beat of the next fill.
- **Stray acknowledges.** `resp_i` in IDLE or a DONE state is ignored, with no state or data change.
- **Input stability.** `address_i` and `line_i` changes after accept have no effect.
- **Reset.** Asserting `rst_n` low at any time, including mid-burst, forces:
  - state = IDLE, `cnt` = 0;
  - `read_o` = `write_o` = `resp_o` = 0;
  - `address_o` = 0, `line_o` = 0, `burst_o` = 0, write buffer = 0.
  
  The partial burst is discarded. The memory model must be reset alongside.

## Timing
- **Accept.** A request seen at edge N gives `read_o`/`write_o` = 1 and a valid `address_o` from cycle N+1.
- **Beats.** One beat per `resp_i` cycle. Beats may be back-to-back or separated by any number of idle cycles.
- **Latency.** Minimum is 6 cycles from request to `resp_o`: 1 accept, 4 beats, 1 done. `resp_o` rises the cycle after the fourth `resp_i`.
- **Request hold.** `read_o`/`write_o` stay high continuously from accept through the fourth beat's cycle, and drop together with the rise of `resp_o`.
- **Write data.** `burst_o` changes only on the edge following an acknowledged beat.
- **Back-to-back.** The minimum spacing between consecutive operations is one IDLE cycle after each `resp_o`.

## Test plan
- **Contiguous fill.** Read at 0x0000_1234 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles:
  - `address_o` = 0x0000_1220;
  - `line_o` = {0x4444…, 0x3333…, 0x2222…, 0x1111…};
  - `resp_o` is a single pulse 6 cycles after the request.
- **Gapped fill.** Same beats with 0–3 idle cycles between each `resp_i`: identical `line_o`, `read_o` held continuously, `resp_o` one cycle after the last beat.
- **Write-back.** Write of `line_i` = 0xDDDD…_CCCC…_BBBB…_AAAA… to 0x8000_001F:
  - `address_o` = 0x8000_0000;
  - `burst_o` sequence is 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD…;
  - changing `line_i` after accept does not alter `burst_o`.
- **Simultaneous requests.** `read_i` and `write_i` both high: write-back completes first. Then, with `read_i` still high, a fill follows after one IDLE cycle.
- **Reset mid-fill.** Drop `rst_n` after 2 beats: all outputs go to 0 immediately. After release, a new fill yields only the new data, with no stale beats.
- **Stray acknowledges.** `resp_i` pulses while IDLE: no state change, `line_o` and `resp_o` unchanged.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache side, the adaptor and the physical-memory port.
// The adaptor connects through the slave modport. The cache controller and the
// memory model together take the master side.
interface cacheline_adaptor_if #(
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64,
    parameter int ADDR_WIDTH = 32
);
    // Cache side
    logic [ADDR_WIDTH-1:0] address_i;
    logic                  read_i;
    logic                  write_i;
    logic [LINE_BITS-1:0]  line_i;
    logic [LINE_BITS-1:0]  line_o;
    logic                  resp_o;

    // Physical-memory side
    logic [ADDR_WIDTH-1:0] address_o;
    logic                  read_o;
    logic                  write_o;
    logic [BEAT_BITS-1:0]  burst_o;
    logic [BEAT_BITS-1:0]  burst_i;
    logic                  resp_i;

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: gathers four 64-bit memory beats into one 256-bit fill
// line and splits a 256-bit dirty line into four write-back beats.
// Every output is a register, so the memory port and the data array never see
// combinational paths through this block.
module cacheline_adaptor #(
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    cacheline_adaptor_if.slave bus
);

    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DONE,
        WR,
        WR_DONE
    } state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic [LINE_BITS-1:0]  wr_buf;
    logic [LINE_BITS-1:0]  line_q;
    logic                  resp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  read_q;
    logic                  write_q;
    logic [BEAT_BITS-1:0]  burst_q;

    // The byte offset within a line is dropped on purpose: memory always
    // transfers whole, line-aligned bursts.
    logic unused_offset_bits;
    assign unused_offset_bits = ^bus.address_i[OFFSET_BITS-1:0];

    assign bus.line_o    = line_q;
    assign bus.resp_o    = resp_q;
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.burst_o   = burst_q;

    // Request accept, beat sequencing and all registered outputs.
    // Write-back wins over a simultaneous fill because the victim must leave
    // before its slot is refilled. The write beat advances only after memory
    // acknowledges the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            wr_buf  <= '0;
            line_q  <= '0;
            resp_q  <= 1'b0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            burst_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_i || bus.read_i) begin
                        addr_q <= {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        wr_buf <= bus.line_i;
                        cnt    <= 2'd0;
                    end
                    if (bus.write_i) begin
                        state   <= WR;
                        write_q <= 1'b1;
                        burst_q <= bus.line_i[BEAT_BITS-1:0];
                    end else if (bus.read_i) begin
                        state  <= RD;
                        read_q <= 1'b1;
                    end
                end

                RD: begin
                    if (bus.resp_i) begin
                        line_q[int'(cnt)*BEAT_BITS +: BEAT_BITS] <= bus.burst_i;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state  <= RD_DONE;
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                        end
                    end
                end

                WR: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state   <= WR_DONE;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else begin
                            burst_q <= wr_buf[(int'(cnt) + 1)*BEAT_BITS +: BEAT_BITS];
                        end
                    end
                end

                RD_DONE, WR_DONE: begin
                    resp_q <= 1'b0;
                    cnt    <= 2'd0;
                    state  <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= 2'd0;
                    resp_q  <= 1'b0;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor. The bench acts as both the cache
// controller and the memory model. Expected addresses, lines and write beats
// are queued when a request is issued and consumed when the adaptor presents
// them.
module tb_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        tag;
        logic [255:0] value;
    } exp_t;

    exp_t sb [$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle     = 0;
    int   req_cycle = 0;

    localparam logic [255:0] L1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    localparam logic [255:0] L2 = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    localparam logic [255:0] L3 = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
                                   64'h0101_0101_0101_0101, 64'h0000_0000_0000_00F0};
    localparam logic [255:0] L4 = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                                   64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA};
    localparam logic [255:0] L5 = {64'hF5F5_F5F5_F5F5_F5F5, 64'hE5E5_E5E5_E5E5_E5E5,
                                   64'hD5D5_D5D5_D5D5_D5D5, 64'hC5C5_C5C5_C5C5_C5C5};
    localparam logic [255:0] L6 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                   64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    localparam logic [255:0] L7 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};

    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [255:0] observed,
                                input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input string tag, input logic [255:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [255:0] observed);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_underflow: observed %h expected nothing queued", observed);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks--;
            check_output(e.tag, observed, e.value);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_read_o"}, bus.read_o, 1'b0);
        check_bit({tag, "_write_o"}, bus.write_o, 1'b0);
        check_bit({tag, "_resp_o"}, bus.resp_o, 1'b0);
        check_output({tag, "_address_o"}, 256'(bus.address_o), 256'h0);
        check_output({tag, "_line_o"}, bus.line_o, 256'h0);
        check_output({tag, "_burst_o"}, 256'(bus.burst_o), 256'h0);
    endtask

    // Issue a request and check the accept cycle and the aligned address.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [255:0] line, input logic [31:0] exp_addr);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = line;
        push_exp("address_o", 256'(exp_addr));
        req_cycle = cycle;
        tick();
        check_bit("accept_read_o", bus.read_o, rd && !wr);
        check_bit("accept_write_o", bus.write_o, wr);
        check_next(256'(bus.address_o));
    endtask

    // Memory side of a fill. gaps holds 2-bit idle counts before each beat.
    // prior is the line content expected before the first beat lands.
    task automatic fill_beats(input logic [255:0] beats, input logic [7:0] gaps,
                              input logic [255:0] prior, input logic hold_read);
        logic [255:0] exp_line;
        int           total_gaps;
        exp_line   = prior;
        total_gaps = 0;
        push_exp("fill_line_o", beats);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = 64'hDEAD_BEEF_0BAD_F00D;
                tick();
                total_gaps++;
                check_bit("fill_gap_read_o", bus.read_o, 1'b1);
                check_output("fill_gap_line_o", bus.line_o, exp_line);
            end
            bus.resp_i  = 1'b1;
            bus.burst_i = beats[64*i +: 64];
            tick();
            bus.resp_i  = 1'b0;
            exp_line[64*i +: 64] = beats[64*i +: 64];
            if (i < 3) begin
                check_bit("fill_beat_read_o", bus.read_o, 1'b1);
                check_bit("fill_beat_resp_o", bus.resp_o, 1'b0);
                check_output("fill_partial_line_o", bus.line_o, exp_line);
            end
        end
        check_bit("fill_done_resp_o", bus.resp_o, 1'b1);
        check_bit("fill_done_read_o", bus.read_o, 1'b0);
        check_output("fill_latency", 256'(cycle - req_cycle + 1), 256'(6 + total_gaps));
        check_next(bus.line_o);
        bus.read_i  = hold_read;
        bus.write_i = 1'b0;
        tick();
        check_bit("fill_idle_resp_o", bus.resp_o, 1'b0);
        check_bit("fill_idle_read_o", bus.read_o, 1'b0);
        check_output("fill_stable_line_o", bus.line_o, beats);
    endtask

    // Memory side of a write-back. Optionally scrambles line_i/address_i
    // after accept; the beats must still come from the accepted line.
    task automatic write_beats(input logic [255:0] exp_line, input logic [7:0] gaps,
                               input logic scramble, input logic hold_read);
        for (int i = 0; i < 4; i++)
            push_exp($sformatf("burst_o_beat%0d", i), 256'(exp_line[64*i +: 64]));
        if (scramble) begin
            bus.line_i    = {8{32'h5A5A_A5A5}};
            bus.address_i = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
                bus.resp_i = 1'b0;
                tick();
                check_bit("wr_gap_write_o", bus.write_o, 1'b1);
                check_output("wr_gap_burst_o", 256'(bus.burst_o), 256'(exp_line[64*i +: 64]));
            end
            check_next(256'(bus.burst_o));
            bus.resp_i = 1'b1;
            tick();
            bus.resp_i = 1'b0;
            if (i < 3) begin
                check_bit("wr_beat_write_o", bus.write_o, 1'b1);
                check_bit("wr_beat_resp_o", bus.resp_o, 1'b0);
            end
        end
        check_bit("wr_done_resp_o", bus.resp_o, 1'b1);
        check_bit("wr_done_write_o", bus.write_o, 1'b0);
        check_bit("wr_done_read_o", bus.read_o, 1'b0);
        bus.write_i = 1'b0;
        bus.read_i  = hold_read;
        tick();
        check_bit("wr_idle_resp_o", bus.resp_o, 1'b0);
        check_bit("wr_idle_write_o", bus.write_o, 1'b0);
        check_bit("wr_idle_read_o", bus.read_o, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] contiguous fill");
        apply_stimulus(1'b1, 1'b0, 32'h0000_1234, '0, 32'h0000_1220);
        fill_beats(L1, 8'h00, 256'h0, 1'b0);

        $display("[TB] gapped fill");
        apply_stimulus(1'b1, 1'b0, 32'h0000_2040, '0, 32'h0000_2040);
        fill_beats(L1, 8'hE4, L1, 1'b0);

        $display("[TB] write-back");
        apply_stimulus(1'b0, 1'b1, 32'h8000_001F, L2, 32'h8000_0000);
        write_beats(L2, 8'h62, 1'b1, 1'b0);
        check_output("wr_after_address_o", 256'(bus.address_o), 256'h8000_0000);

        $display("[TB] stray acknowledges in idle");
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            tick();
            check_bit("stray_resp_o", bus.resp_o, 1'b0);
            check_bit("stray_read_o", bus.read_o, 1'b0);
            check_bit("stray_write_o", bus.write_o, 1'b0);
            check_output("stray_line_o", bus.line_o, L1);
        end
        bus.resp_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0000_0100);
        fill_beats(L3, 8'h00, L1, 1'b0);

        $display("[TB] simultaneous requests");
        apply_stimulus(1'b1, 1'b1, 32'h0000_4008, L4, 32'h0000_4000);
        write_beats(L4, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0000_4008, '0, 32'h0000_4000);
        fill_beats(L5, 8'h11, L3, 1'b0);

        $display("[TB] reset mid-fill");
        apply_stimulus(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_3000);
        for (int i = 0; i < 2; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = L7[64*i +: 64];
            tick();
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        check_all_zero("held_reset");
        rst_n = 1'b1;
        tick();
        apply_stimulus(1'b1, 1'b0, 32'h0000_3000, '0, 32'h0000_3000);
        fill_beats(L6, 8'h00, 256'h0, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
